// File: rtl/div_ctrl.sv
// Sequencer between the EXE stage and the 33-cycle iterative divider.
// Holds one div/mod request, drives the divider and returns the tagged result.
//
//   state | meaning
//   IDLE  | no request held, ready for a new one
//   BUSY  | divider running on the held operands (div_en high)
//   DONE  | result presented on resp_*, waiting for resp_ready
module div_ctrl #(
    parameter int TAG_W    = 5,
    parameter bit REUSE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_x,
    input  logic [31:0]      req_y,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             div_en,
    output logic             div_signed,
    output logic [31:0]      div_x,
    output logic [31:0]      div_y,
    input  logic [31:0]      div_s,
    input  logic [31:0]      div_r,
    input  logic             div_complete
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic             accept;
    logic             hit;
    logic [31:0]      hit_data;
    logic             cache_wr;

    assign req_ready = ~flush & ((state == IDLE) | ((state == DONE) & resp_ready));
    assign accept    = req_valid & req_ready;
    // A flush in the completing cycle drops the result, so the cache must not see it either.
    assign cache_wr  = (state == BUSY) & div_complete & ~flush;

    generate
        if (REUSE_EN) begin : g_cache
            logic        cache_valid;
            logic        cache_sgn;
            logic [31:0] cache_x;
            logic [31:0] cache_y;
            logic [31:0] cache_s;
            logic [31:0] cache_r;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    cache_valid <= 1'b0;
                    cache_sgn   <= 1'b0;
                    cache_x     <= '0;
                    cache_y     <= '0;
                    cache_s     <= '0;
                    cache_r     <= '0;
                end else if (cache_wr) begin
                    cache_valid <= 1'b1;
                    cache_sgn   <= div_signed;
                    cache_x     <= div_x;
                    cache_y     <= div_y;
                    cache_s     <= div_s;
                    cache_r     <= div_r;
                end
            end

            assign hit      = cache_valid & (req_x == cache_x) & (req_y == cache_y)
                              & (~req_op[1] == cache_sgn);
            assign hit_data = req_op[0] ? cache_r : cache_s;
        end else begin : g_no_cache
            assign hit      = 1'b0;
            assign hit_data = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            op_q       <= '0;
            tag_q      <= '0;
            div_en     <= 1'b0;
            div_signed <= 1'b0;
            div_x      <= '0;
            div_y      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
        end else if (flush) begin
            state      <= IDLE;
            div_en     <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                BUSY: begin
                    if (div_complete) begin
                        resp_data  <= op_q[0] ? div_r : div_s;
                        resp_tag   <= tag_q;
                        resp_valid <= 1'b1;
                        div_en     <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: ;
            endcase
            // Accept only happens in IDLE or DONE, so it overrides the DONE retirement above.
            if (accept) begin
                div_x      <= req_x;
                div_y      <= req_y;
                div_signed <= ~req_op[1];
                op_q       <= req_op;
                tag_q      <= req_tag;
                if (hit) begin
                    resp_data  <= hit_data;
                    resp_tag   <= req_tag;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end else begin
                    div_en <= 1'b1;
                    state  <= BUSY;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural divider environment, transaction-level reference
// model compared every cycle, directed literal checks and a randomized phase.
module tb_div_ctrl;

    localparam int TAG_W = 5;

    logic             clk;
    logic             resetn;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_x;
    logic [31:0]      req_y;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             div_en;
    logic             div_signed;
    logic [31:0]      div_x;
    logic [31:0]      div_y;
    logic [31:0]      div_s;
    logic [31:0]      div_r;
    logic             div_complete;

    int n_cmp  = 0;
    int n_fail = 0;
    bit run_cmp = 0;

    div_ctrl #(.TAG_W(TAG_W), .REUSE_EN(1'b1)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_tag(resp_tag),
        .div_en(div_en), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
        .div_s(div_s), .div_r(div_r), .div_complete(div_complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic result {quotient, remainder}; divide-by-zero gives all-ones / dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic sgn);
        logic [31:0] ax, ay, uq, ur, q, r;
        if (y == 32'd0) return {32'hFFFF_FFFF, x};
        ax = (sgn && x[31]) ? (~x + 32'd1) : x;
        ay = (sgn && y[31]) ? (~y + 32'd1) : y;
        uq = ax / ay;
        ur = ax % ay;
        q  = (sgn && (x[31] ^ y[31])) ? (~uq + 32'd1) : uq;
        r  = (sgn && x[31]) ? (~ur + 32'd1) : ur;
        return {q, r};
    endfunction

    // Divider environment: counts while enabled, done when the count reaches 33.
    logic [5:0] e_cnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) e_cnt <= '0;
        else         e_cnt <= div_en ? e_cnt + 6'd1 : 6'd0;
    end
    assign div_complete   = div_en && (e_cnt == 6'd33);
    assign {div_s, div_r} = ref_div(div_x, div_y, div_signed);

    // Reference model: one pending divide with a cycle countdown, one response slot, one cache entry.
    bit               m_pend, m_rv, m_acc, m_sgn, m_op0;
    int               m_left;
    logic [31:0]      m_x, m_y, m_rd;
    logic [TAG_W-1:0] m_tag, m_rt;
    bit               c_valid, c_sgn;
    logic [31:0]      c_x, c_y, c_q, c_r;
    bit               m_rdy;
    logic [63:0]      m_qr;

    function automatic bit model_ready();
        return !flush && !m_pend && (!m_rv || resp_ready);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_pend = 0; m_rv = 0; m_acc = 0; m_sgn = 0; m_op0 = 0; m_left = 0;
            m_x = '0; m_y = '0; m_rd = '0; m_tag = '0; m_rt = '0;
            c_valid = 0; c_sgn = 0; c_x = '0; c_y = '0; c_q = '0; c_r = '0;
        end else begin
            m_acc = 0;
            if (flush) begin
                m_pend = 0;
                m_rv   = 0;
            end else begin
                m_rdy = model_ready();
                if (m_pend) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_qr   = ref_div(m_x, m_y, m_sgn);
                        m_rd   = m_op0 ? m_qr[31:0] : m_qr[63:32];
                        m_rt   = m_tag;
                        m_rv   = 1;
                        m_pend = 0;
                        c_valid = 1; c_x = m_x; c_y = m_y; c_sgn = m_sgn;
                        c_q = m_qr[63:32]; c_r = m_qr[31:0];
                    end
                end else if (m_rv && resp_ready) begin
                    m_rv = 0;
                end
                if (req_valid && m_rdy) begin
                    m_acc = 1;
                    m_x = req_x; m_y = req_y; m_sgn = ~req_op[1]; m_op0 = req_op[0];
                    m_tag = req_tag;
                    if (c_valid && c_x == req_x && c_y == req_y && c_sgn == ~req_op[1]) begin
                        m_rv = 1;
                        m_rd = req_op[0] ? c_r : c_q;
                        m_rt = req_tag;
                    end else begin
                        m_pend = 1;
                        m_left = 34;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait expired at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (resetn && run_cmp) begin
            chk("req_ready", req_ready, model_ready());
            chk("resp_valid", resp_valid, m_rv);
            chk("div_en", div_en, m_pend);
            chk("div_x", div_x, m_x);
            chk("div_y", div_y, m_y);
            chk("div_signed", div_signed, m_sgn);
            if (m_rv) begin
                chk("resp_data", resp_data, m_rd);
                chk("resp_tag", resp_tag, m_rt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [TAG_W-1:0] tag);
        int n;
        req_valid = 1'b1; req_op = op; req_x = x; req_y = y; req_tag = tag;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 200);
        if (!m_acc) timeout("accept");
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!resp_valid) timeout("resp_valid");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] px [5];
        logic [31:0] py [6];
        px[0] = 32'd100; px[1] = 32'd1000; px[2] = 32'hFFFF_FFF9; px[3] = 32'h8000_0000; px[4] = 32'd20;
        py[0] = 32'd7; py[1] = 32'd33; py[2] = 32'd2; py[3] = 32'd0; py[4] = 32'hFFFF_FFFF; py[5] = 32'd3;

        resetn = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0;
        req_tag = '0; resp_ready = 1'b1;
        #1 resetn = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_div_en", div_en, 0);
        chk("rst_div_x", div_x, 0);
        chk("rst_resp_data", resp_data, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        run_cmp = 1;
        tick();

        // div.w 100/7
        send(2'b00, 32'd100, 32'd7, 5'd3);
        chk("t1_div_en", div_en, 1);
        wait_resp(lat);
        chk("t1_latency", lat, 35);
        chk("t1_data", resp_data, 32'd14);
        chk("t1_tag", resp_tag, 5'd3);
        tick();

        // mod.w then mod.wu on -7 / 2
        send(2'b01, 32'hFFFF_FFF9, 32'd2, 5'd4);
        wait_resp(lat);
        chk("t2_latency_s", lat, 35);
        chk("t2_data_s", resp_data, 32'hFFFF_FFFF);
        tick();
        send(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd5);
        wait_resp(lat);
        chk("t2_latency_u", lat, 35);
        chk("t2_data_u", resp_data, 32'h0000_0001);
        tick();

        // div.w 1000/33 followed back-to-back by mod.w on the same operands
        send(2'b00, 32'd1000, 32'd33, 5'd7);
        req_valid = 1'b1; req_op = 2'b01; req_x = 32'd1000; req_y = 32'd33; req_tag = 5'd8;
        wait_resp(lat);
        chk("t3_latency", lat, 35);
        chk("t3_data_div", resp_data, 32'd30);
        chk("t3_tag_div", resp_tag, 5'd7);
        tick();
        req_valid = 1'b0;
        chk("t3_reuse_valid", resp_valid, 1);
        chk("t3_data_mod", resp_data, 32'd10);
        chk("t3_tag_mod", resp_tag, 5'd8);
        chk("t3_div_en", div_en, 0);
        tick();

        // flush mid-divide, then the same divide runs in full
        send(2'b10, 32'd20, 32'd3, 5'd9);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_div_en", div_en, 0);
        chk("t4_resp_valid", resp_valid, 0);
        repeat (40) tick();
        chk("t4_no_resp", resp_valid, 0);
        send(2'b10, 32'd20, 32'd3, 5'd10);
        wait_resp(lat);
        chk("t4_latency", lat, 35);
        chk("t4_data", resp_data, 32'd6);
        tick();

        // back-pressure on the response
        resp_ready = 1'b0;
        send(2'b01, 32'd50, 32'd8, 5'd11);
        wait_resp(lat);
        chk("t5_latency", lat, 35);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_valid", resp_valid, 1);
            chk("t5_hold_data", resp_data, 32'd2);
            chk("t5_hold_tag", resp_tag, 5'd11);
            chk("t5_req_ready", req_ready, 0);
            chk("t5_div_en", div_en, 0);
        end
        resp_ready = 1'b1;
        tick();
        chk("t5_released", resp_valid, 0);
        chk("t5_idle_ready", req_ready, 1);

        // asynchronous reset mid-divide
        send(2'b00, 32'd12345, 32'd6, 5'd12);
        repeat (10) tick();
        #2 resetn = 1'b0;
        #1;
        chk("t6_req_ready", req_ready, 1);
        chk("t6_resp_valid", resp_valid, 0);
        chk("t6_div_en", div_en, 0);
        chk("t6_div_x", div_x, 0);
        chk("t6_div_y", div_y, 0);
        chk("t6_div_signed", div_signed, 0);
        chk("t6_resp_data", resp_data, 0);
        chk("t6_resp_tag", resp_tag, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        send(2'b10, 32'hFFFF_FFF0, 32'h10, 5'd13);
        wait_resp(lat);
        chk("t6_latency", lat, 35);
        chk("t6_data", resp_data, 32'h0FFF_FFFF);
        tick();

        // randomized traffic with a small operand pool so reuse hits are frequent
        for (int c = 0; c < 3000; c++) begin
            if (!req_valid || m_acc || $urandom_range(3) == 0) begin
                req_valid = ($urandom_range(2) != 0);
                req_op    = 2'($urandom_range(3));
                req_x     = ($urandom_range(5) == 5) ? $urandom : px[$urandom_range(4)];
                req_y     = ($urandom_range(6) == 6) ? $urandom : py[$urandom_range(5)];
                req_tag   = TAG_W'($urandom_range(31));
            end
            resp_ready = ($urandom_range(3) != 0);
            flush      = ($urandom_range(39) == 0);
            tick();
        end
        flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
